// File: rtl/x9_pkg.sv
// Shared types for the x9 register-file helper blocks.
// Holds the register-dump FSM state encoding.
package x9_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StFin
  } reg_dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// Streams a contiguous, wrapping range of register-file entries out over a valid/ready port.
// Reads through the file's combinational port; one element per cycle under continuous ready.
module reg_dump
  import x9_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] base_addr,
  input  logic [D:0]   count,
  output logic [D-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         busy,
  output logic         done
);

  reg_dump_state_t state_q, state_d;
  logic [D-1:0]    cur_addr_q, cur_addr_d;
  logic [D:0]      remaining_q, remaining_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [D-1:0]    out_addr_q, out_addr_d;
  logic [D-1:0]    next_addr;

  // Address arithmetic wraps naturally at D bits.
  assign next_addr = cur_addr_q + D'(1);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    rd_addr     = cur_addr_q;
    out_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          if (count == '0) begin
            state_d = StFin;
          end else begin
            cur_addr_d  = base_addr;
            remaining_d = count;
            state_d     = StFetch;
          end
        end
      end
      StFetch: begin
        out_data_d = rd_data;
        out_addr_d = cur_addr_q;
        state_d    = StSend;
      end
      StSend: begin
        // Prefetch the next element so a handshake can reload in the same cycle.
        rd_addr   = next_addr;
        out_valid = 1'b1;
        if (out_ready) begin
          if (remaining_q > (D+1)'(1)) begin
            out_data_d  = rd_data;
            out_addr_d  = next_addr;
            cur_addr_d  = next_addr;
            remaining_d = remaining_q - (D+1)'(1);
          end else begin
            remaining_d = '0;
            state_d     = StFin;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_addr = out_addr_q;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: stimulus pushes expected elements, a negedge monitor pops them.
// Register file is modelled as a plain array read combinationally.
module tb_reg_dump;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [D-1:0] base_addr = '0;
  logic [D:0]   count = '0;
  logic [D-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [D-1:0] out_addr;
  logic         busy;
  logic         done;

  logic [W-1:0] regs [N];
  logic [D+W-1:0] exp_q[$];
  int exp_done = 0;
  int n_checks = 0;
  int n_pass = 0;

  reg_dump #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: outputs are stable at the falling edge; a handshake here is taken at the next rise.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_element", 32'(out_addr), 32'hffff_ffff);
        end else if (out_ready) begin
          logic [D+W-1:0] e;
          e = exp_q.pop_front();
          chk("elem_addr", 32'(out_addr), 32'(e[D+W-1:W]));
          chk("elem_data", 32'(out_data), 32'(e[W-1:0]));
        end else begin
          chk("hold_addr", 32'(out_addr), 32'(exp_q[0][D+W-1:W]));
          chk("hold_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
        end
      end
      if (done) begin
        chk("done_expected", 32'(exp_done > 0), 32'd1);
        chk("done_after_all_elems", 32'(exp_q.size()), 32'd0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on element 2;
  // 3: random ready plus stray start pulses while busy.
  task automatic run_dump(input logic [D-1:0] base, input logic [D:0] cnt, input int mode,
                          input bit timed);
    int k;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    out_ready = (mode == 0 || mode == 2) ? 1'b1 : 1'($urandom_range(1));
    for (int i = 0; i < int'(cnt); i++) begin
      int a;
      a = (int'(base) + i) % N;
      exp_q.push_back({D'(a), regs[a]});
    end
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    if (timed) begin
      if (cnt == 0) begin
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_no_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("lat_fetch_valid", 32'(out_valid), 32'd0);
        chk("lat_fetch_busy", 32'(busy), 32'd1);
      end
    end
    while (busy && k < 300) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (timed) begin
        if (cnt == 0) begin
          if (k == 1) chk("cnt0_idle", 32'({busy, done}), 32'd0);
        end else if (k <= int'(cnt)) begin
          chk("stream_valid", 32'(out_valid), 32'd1);
        end else if (k == int'(cnt) + 1) begin
          chk("fin_done", 32'({done, out_valid}), 32'b10);
        end else if (k == int'(cnt) + 2) begin
          chk("back_idle", 32'({busy, done}), 32'd0);
        end
      end
      case (mode)
        0: out_ready = 1'b1;
        2: out_ready = !(k >= 2 && k <= 4);
        default: out_ready = ($urandom_range(9) < 7);
      endcase
      if (mode == 3 && busy && $urandom_range(3) == 0) begin
        start     = 1'b1;
        base_addr = D'($urandom);
        count     = (D+1)'($urandom_range(N));
      end
    end
    start = 1'b0;
    chk("dump_timeout", 32'(k >= 300), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_seen", 32'(exp_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = W'(i * 2);
    #1;
    chk("rst_outputs", 32'({out_valid, busy, done}), 32'd0);
    chk("rst_data_addr", 32'({out_data, out_addr, rd_addr}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_dump(4'd3, 5'd4, 0, 1'b1);
    run_dump(4'd14, 5'd4, 0, 1'b1);
    run_dump(4'd2, 5'd4, 2, 1'b0);
    run_dump(4'd0, 5'd0, 0, 1'b1);
    run_dump(4'd0, 5'd16, 0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) regs[i] = W'($urandom);
      run_dump(D'($urandom), (D+1)'($urandom_range(N)), (t % 2) ? 3 : 1, 1'b0);
      @(posedge clk); #1;
    end

    // Abandon a dump mid-stream.
    start = 1'b1; base_addr = 4'd5; count = 5'd6; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back({D'(5 + i), regs[5 + i]});
    exp_done++;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_sending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_outputs", 32'({out_valid, busy, done}), 32'd0);
    chk("mid_rst_data_addr", 32'({out_data, out_addr, rd_addr}), 32'd0);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_done", 32'(done), 32'd0);
    run_dump(4'd0, 5'd1, 0, 1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
